// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, direct-mapped data cache between the CPU data port
// and a multi-cycle backing memory with a request/ready handshake.
// Lines are 4 x 16-bit words; 2**IDX_BITS lines.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | serve hits in zero cycles; a miss raises stall and leaves
// WRITEBACK | victim line is dirty: hold mem_we with its data until mem_rdy
// ALLOCATE  | hold mem_re for the requested line; fill it on mem_rdy

module dcache_ctrl #(
    parameter int IDX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic [13:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
`ifdef DCACHE_STATS_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy
);

    localparam int TAG_BITS = 14 - IDX_BITS;
    localparam int LINES    = 2 ** IDX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [63:0]         data_arr [LINES];
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          off;
    logic [5:0]          bit_lo;
    logic                req;
    logic                hit;

    // Strobes from the FSM to the array updates
    logic wr_hit;
    logic fill;
    logic wb_done;
    logic miss_evt;

    assign idx    = addr[IDX_BITS+1:2];
    assign tag    = addr[15:IDX_BITS+2];
    assign off    = addr[1:0];
    assign bit_lo = {off, 4'b0000};
    assign req    = re | we;
    assign hit    = valid[idx] & (tag_arr[idx] == tag);

    // State register; reset aborts any handshake in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; everything idles while reset is asserted so a
    // request held across reset does not show up as stall
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        rd_data   = 16'h0000;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 14'h0000;
        mem_wdata = 64'h0;
        wr_hit    = 1'b0;
        fill      = 1'b0;
        wb_done   = 1'b0;
        miss_evt  = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (we) begin
                                wr_hit = 1'b1;
                            end else begin
                                rd_data = data_arr[idx][bit_lo +: 16];
                            end
                        end else begin
                            stall    = 1'b1;
                            miss_evt = 1'b1;
                            state_nxt = (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    stall     = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_arr[idx], idx};
                    mem_wdata = data_arr[idx];
                    if (mem_rdy) begin
                        wb_done   = 1'b1;
                        state_nxt = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    stall    = 1'b1;
                    mem_re   = 1'b1;
                    mem_addr = {tag, idx};
                    if (mem_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Data and tag storage: line fill from memory or single-word write hit
    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[idx] <= mem_rdata;
            tag_arr[idx]  <= tag;
        end else if (wr_hit) begin
            data_arr[idx][bit_lo +: 16] <= wrt_data;
        end
    end

    // Valid/dirty bookkeeping; reset invalidates everything, dirty data is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wb_done) begin
            dirty[idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    // The cycle right after a fill serves the request that missed; that
    // access is already counted as a miss, so it must not count as a hit.
    logic fill_done;

    // Saturating hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_done <= 1'b0;
            hit_cnt   <= 16'h0000;
            miss_cnt  <= 16'h0000;
        end else begin
            fill_done <= fill;
            if ((state == IDLE) && req && hit && !fill_done && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'h0001;
            end
            if (miss_evt && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Write-back, direct-mapped data cache that answers the pipeline's data-memory request port (addr / re / we / wrt_data -> rd_data) in place of a single-cycle data memory.
- Hits complete in zero added cycles. Misses raise stall while the block fills lines from, and evicts lines to, a multi-cycle backing memory over a request/ready handshake.
- The CPU side holds its request and freezes the pipeline while stall is high.

Parameters:
- IDX_BITS, 3, index width; number of lines = 2**IDX_BITS. Line = 4 x 16-bit words. tag = addr[15:IDX_BITS+2].
- TAG_BITS, 14-IDX_BITS, derived; not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- addr  in  16  CPU word address: offset addr[1:0], index addr[IDX_BITS+1:2], tag above
- re  in  1  CPU read request
- we  in  1  CPU write request
- wrt_data  in  16  CPU write data
- rd_data  out  16  read data (combinational)
- stall  out  1  request not yet serviced
- mem_addr  out  14  backing line address {tag,index}
- mem_re  out  1  line read request
- mem_we  out  1  line write request
- mem_wdata  out  64  evicted line, word0 in [15:0]
- mem_rdata  in  64  fill line, word0 in [15:0]
- mem_rdy  in  1  backing memory completes current request this cycle

Behaviour:
- Reset (async): every valid and dirty bit = 0; state = IDLE; stall = 0; mem_re = mem_we = 0; mem_addr = 0; mem_wdata = 0; rd_data = 0. Data and tag arrays are not reset.
- req = re | we. hit = valid[idx] & (tag_arr[idx] == tag).
- If we = 1 and re = 1 together, the access is a write and rd_data = 0.
- IDLE, req & hit:
  - stall = 0.
  - Read: rd_data = line[idx][offset] in the same cycle.
  - Write: word updated and dirty[idx] set at posedge.
- IDLE, req & ~hit:
  - stall = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if valid[idx] & dirty[idx], otherwise ALLOCATE.
- IDLE, ~req: stall = 0, rd_data = 0.
- WRITEBACK:
  - Outputs: mem_we = 1, mem_addr = {tag_arr[idx], idx}, mem_wdata = line[idx], stall = 1.
  - On mem_rdy: go to ALLOCATE and clear dirty[idx].
- ALLOCATE:
  - Outputs: mem_re = 1, mem_addr = {tag, idx}, stall = 1.
  - On mem_rdy: latch mem_rdata into line[idx], tag_arr[idx] = tag, valid = 1, dirty = 0, go to IDLE.
  - The request then hits on the following cycle, so a clean miss adds (fill wait + 1) stall cycles.
- mem_re and mem_we are never high together. Each is held high with stable address/data until mem_rdy. mem_rdy is ignored in IDLE.
- The CPU holds addr/re/we/wrt_data stable while stall = 1. Changes to them during a miss are undefined.
- req dropping during a miss does not abort the fill; the FSM completes and returns to IDLE.
- Reset mid-operation: FSM aborts immediately and all lines are invalidated. Dirty data is lost by design.
- Index wrap: addresses differing only in tag conflict on the same line. No associativity.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[15:0] and miss_cnt[15:0], both reset to 0.
  - hit_cnt increments once per serviced request that hit in IDLE without a preceding miss.
  - miss_cnt increments once per miss, on the IDLE->WRITEBACK/ALLOCATE transition.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold read: after reset, re=1 addr=16'h0024, mem_rdy after 3 cycles with mem_rdata=64'h0004_0003_0002_0001 -> mem_re with mem_addr=14'h0009 for 3 cycles; stall for 4 cycles total; then rd_data=16'h0001, stall=0.
- Write hit then read: we=1 addr=16'h0025 wrt_data=16'hBEEF on the filled line -> stall=0, no mem traffic; next re addr=16'h0025 -> rd_data=16'hBEEF.
- Dirty eviction: re addr=16'h0044 (same index 1, tag 2) with the line dirty -> WRITEBACK first: mem_we=1, mem_addr=14'h0009, mem_wdata=64'h0004_0003_BEEF_0001; then ALLOCATE with mem_addr=14'h0011; mem_re and mem_we never overlap.
- Simultaneous re & we: re=1 we=1 addr=16'h0044 wrt_data=16'h1234 -> rd_data=0; word written; dirty set.
- Reset mid-fill: assert rst_n=0 during ALLOCATE -> stall, mem_re, mem_we = 0 immediately; after release, re addr=16'h0024 misses again.
- DCACHE_STATS_EN: run the sequence above -> miss_cnt and hit_cnt match the expected counts exactly.
